m_dm: RTL and testbench
=======================

M_DM -- requirements
Module: m_dm

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-003 addr  input  32  byte address of the memory-stage access.
REQ-004 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-005 dm_op  input  2  store select: 00 none, 01 sh, 10 sb, 11 sw.
REQ-006 out_op  input  3  load format: 000 word, 010 lb, 100 lh; any other code is treated as word.
REQ-007 rdata  output  32  load result, combinational from current array contents.
REQ-008 fault  output  1  combinational; current access is misaligned or out of range.
REQ-009 fault_sticky  output  1  registered; set by any faulting store, held until reset.
REQ-010 store_cnt  output  16  registered count of committed stores, saturating.

Function
REQ-011 Storage SHALL be a 1024 x 32-bit array indexed by addr[11:2] (4 KiB).
REQ-012 An address SHALL be in range only when addr[31:12] == 0.
REQ-013 Alignment: sw/word load needs addr[1:0]==00; sh/lh needs addr[0]==0; sb/lb has no constraint.
REQ-014 Store decode SHALL take precedence for fault: when dm_op!=00, fault reflects the store's alignment/range; otherwise it reflects the out_op load's.
REQ-015 sw SHALL write all 32 bits of the selected word at the rising edge.
REQ-016 sh SHALL write wdata[15:0] to bits [31:16] when addr[1]=1, else to [15:0]; other bits unchanged.
REQ-017 sb SHALL write wdata[7:0] to byte lane addr[1:0] (lane 0 = bits [7:0]); other bytes unchanged.
REQ-018 A store with fault=1 SHALL NOT modify the array or store_cnt, and SHALL set fault_sticky at that edge.
REQ-019 Load: word returns the full word; lb returns the byte at lane addr[1:0], sign-extended; lh returns the half at addr[1], sign-extended.
REQ-020 A load with fault=1 SHALL return rdata = 32'h0000_0000.
REQ-021 rdata SHALL be computed from pre-edge contents; a store and a read to the same word in one cycle returns old data, with new data visible after the edge.
REQ-022 rdata SHALL be driven from out_op every cycle, independent of dm_op.
REQ-023 store_cnt SHALL increment by 1 on each committed store and hold at 16'hFFFF once reached.
REQ-024 Latency: writes commit at the edge ending the access cycle; reads are zero-latency.

Reset
REQ-025 On reset assertion all 1024 words SHALL become 0, store_cnt=0, fault_sticky=0, asynchronously, without waiting for clk.
REQ-026 While reset is high, stores SHALL be ignored; rdata reads 0 for in-range aligned loads.
REQ-027 A reset asserted mid-cycle during a store SHALL discard that store; no partial write survives.
REQ-028 After reset deasserts, the first rising edge SHALL process accesses normally.

Verification
REQ-029 sw addr=0x10 wdata=0x8765_4321, then word load addr=0x10 -> rdata=0x8765_4321, store_cnt=1.
REQ-030 Preceding word, then sb addr=0x13 wdata=0xAA and lb addr=0x13 -> rdata=0xFFFF_FFAA; word load -> 0xAA65_4321.
REQ-031 sh addr=0x12 wdata=0x7F00, then lh addr=0x12 -> 0x0000_7F00; lh addr=0x11 -> fault=1, rdata=0.
REQ-032 sw addr=0x0000_1000 -> fault=1, fault_sticky=1 after edge, store_cnt unchanged, word 0 unchanged.
REQ-033 Store and load to the same word in one cycle -> rdata shows old value that cycle, new value next cycle.
REQ-034 Pulse reset between edges after stores -> all outputs/registers 0 immediately; 65540 stores -> store_cnt=0xFFFF.

Source files
------------

// File: rtl/m_dm.sv
// rtl/m_dm.sv - 4 KiB data memory for the memory stage with sub-word access, fault detection and store counting
//
// Ports:
//   clk          : sole clock, rising edge
//   reset        : asynchronous active-high reset, clears the array and all registers
//   addr[31:0]   : byte address of the access
//   wdata[31:0]  : store data, right-aligned
//   dm_op[1:0]   : store select (00 none, 01 sh, 10 sb, 11 sw)
//   out_op[2:0]  : load format (000 word, 010 lb, 100 lh, others word)
//   rdata[31:0]  : combinational load result
//   fault        : combinational misaligned/out-of-range flag for the current access
//   fault_sticky : set by any faulting store, held until reset
//   store_cnt    : saturating count of committed stores
module m_dm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  dm_op,
  input  logic [2:0]  out_op,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        fault_sticky,
  output logic [15:0] store_cnt
);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SB   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;
  localparam logic [2:0] LD_LB   = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b100;

  logic [31:0] mem_q [1024];
  logic        fault_sticky_q;
  logic [15:0] store_cnt_q;
  logic [15:0] store_cnt_d;

  logic [9:0]  idx;
  logic [31:0] cur_word;
  logic        in_range;
  logic        st_fault;
  logic        ld_fault;
  logic        st_en;
  logic [31:0] word_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign idx      = addr[11:2];
  assign cur_word = mem_q[idx];
  assign in_range = (addr[31:12] == 20'd0);

  // Alignment/range checks for the store and the load decoded independently;
  // the reported fault follows the store whenever one is requested.
  always_comb begin
    st_fault = 1'b0;
    case (dm_op)
      ST_SW:   st_fault = !in_range || (addr[1:0] != 2'b00);
      ST_SH:   st_fault = !in_range || addr[0];
      ST_SB:   st_fault = !in_range;
      default: st_fault = 1'b0;
    endcase
  end

  always_comb begin
    ld_fault = 1'b0;
    case (out_op)
      LD_LB:   ld_fault = !in_range;
      LD_LH:   ld_fault = !in_range || addr[0];
      default: ld_fault = !in_range || (addr[1:0] != 2'b00);
    endcase
  end

  assign fault = (dm_op != ST_NONE) ? st_fault : ld_fault;

  // Load path reads the pre-edge word, so a same-cycle store is not visible yet.
  always_comb begin
    ld_byte = 8'd0;
    case (addr[1:0])
      2'd0:    ld_byte = cur_word[7:0];
      2'd1:    ld_byte = cur_word[15:8];
      2'd2:    ld_byte = cur_word[23:16];
      default: ld_byte = cur_word[31:24];
    endcase
    ld_half = addr[1] ? cur_word[31:16] : cur_word[15:0];
    rdata   = 32'd0;
    if (!ld_fault) begin
      case (out_op)
        LD_LB:   rdata = {{24{ld_byte[7]}}, ld_byte};
        LD_LH:   rdata = {{16{ld_half[15]}}, ld_half};
        default: rdata = cur_word;
      endcase
    end
  end

  // Read-modify-write merge of the store data into the selected word.
  always_comb begin
    word_d = cur_word;
    case (dm_op)
      ST_SW: word_d = wdata;
      ST_SH: begin
        if (addr[1]) word_d[31:16] = wdata[15:0];
        else         word_d[15:0]  = wdata[15:0];
      end
      ST_SB: begin
        case (addr[1:0])
          2'd0:    word_d[7:0]   = wdata[7:0];
          2'd1:    word_d[15:8]  = wdata[7:0];
          2'd2:    word_d[23:16] = wdata[7:0];
          default: word_d[31:24] = wdata[7:0];
        endcase
      end
      default: word_d = cur_word;
    endcase
  end

  assign st_en       = (dm_op != ST_NONE) && !st_fault;
  assign store_cnt_d = (store_cnt_q == 16'hFFFF) ? store_cnt_q : store_cnt_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem_q[i] <= 32'd0;
      fault_sticky_q <= 1'b0;
      store_cnt_q    <= 16'd0;
    end else begin
      if (st_en) begin
        mem_q[idx]  <= word_d;
        store_cnt_q <= store_cnt_d;
      end
      if ((dm_op != ST_NONE) && st_fault) fault_sticky_q <= 1'b1;
    end
  end

  assign fault_sticky = fault_sticky_q;
  assign store_cnt    = store_cnt_q;

endmodule

// File: tb/tb_m_dm.sv
// tb/tb_m_dm.sv - scoreboard testbench for m_dm
module tb_m_dm;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  dm_op;
  logic [2:0]  out_op;
  logic [31:0] rdata;
  logic        fault;
  logic        fault_sticky;
  logic [15:0] store_cnt;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  m_dm dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .wdata        (wdata),
    .dm_op        (dm_op),
    .out_op       (out_op),
    .rdata        (rdata),
    .fault        (fault),
    .fault_sticky (fault_sticky),
    .store_cnt    (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one access at the falling edge and record what the combinational outputs must show.
  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [1:0] d,
                       input logic [2:0] o, input logic [31:0] er, input logic ef);
    @(negedge clk);
    addr = a; wdata = w; dm_op = d; out_op = o;
    exp_q.push_back('{rdata: er, fault: ef});
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 32'h0; wdata = 32'h0; dm_op = 2'b00; out_op = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rdata !== 32'h0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rdata: rdata=%h fault=%b expected rdata=00000000 fault=0", rdata, fault);
    end
    vectors++;
    if (store_cnt !== 16'h0 || fault_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs: store_cnt=%h sticky=%b expected 0000 0", store_cnt, fault_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sw();
    drive(32'h10, 32'h8765_4321, 2'b11, 3'b000, 32'h0, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || fault !== e.fault) begin
      miscompares++;
      $display("FAIL sw_issue: rdata=%h fault=%b expected rdata=%h fault=%b", rdata, fault, e.rdata, e.fault);
    end
    drive(32'h10, 32'h0, 2'b00, 3'b000, 32'h8765_4321, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || fault !== e.fault) begin
      miscompares++;
      $display("FAIL sw_load: rdata=%h fault=%b expected rdata=%h fault=%b", rdata, fault, e.rdata, e.fault);
    end
    vectors++;
    if (store_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL sw_cnt: store_cnt=%h expected 0001", store_cnt);
    end
  endtask

  task automatic test_sub_word();
    logic [31:0] a_t [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h11};
    logic [31:0] w_t [6] = '{32'hAA, 32'h0, 32'h0, 32'h7F00, 32'h0, 32'h0};
    logic [1:0]  d_t [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [2:0]  o_t [6] = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b100};
    logic [31:0] r_t [6] = '{32'hFFFF_FF87, 32'hFFFF_FFAA, 32'hAA65_4321,
                             32'hFFFF_AA65, 32'h0000_7F00, 32'h0};
    logic        f_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(a_t[i], w_t[i], d_t[i], o_t[i], r_t[i], f_t[i]);
      e = exp_q.pop_front(); vectors++;
      if (rdata !== e.rdata || fault !== e.fault) begin
        miscompares++;
        $display("FAIL sub_word[%0d]: rdata=%h fault=%b expected rdata=%h fault=%b", i, rdata, fault, e.rdata, e.fault);
      end
    end
    drive(32'h10, 32'h0, 2'b00, 3'b010, 32'h0000_0021, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || store_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL sub_word_lb0: rdata=%h cnt=%h expected rdata=%h cnt=0003", rdata, store_cnt, e.rdata);
    end
  endtask

  task automatic test_fault();
    drive(32'h0000_1000, 32'hFFFF_FFFF, 2'b11, 3'b000, 32'h0, 1'b1);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || fault !== e.fault) begin
      miscompares++;
      $display("FAIL oor_store: rdata=%h fault=%b expected rdata=%h fault=%b", rdata, fault, e.rdata, e.fault);
    end
    drive(32'h0, 32'h0, 2'b00, 3'b000, 32'h0, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || fault_sticky !== 1'b1 || store_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL oor_after: rdata=%h sticky=%b cnt=%h expected %h 1 0003", rdata, fault_sticky, store_cnt, e.rdata);
    end
    drive(32'h12, 32'h1234_5678, 2'b11, 3'b000, 32'h0, 1'b1);
    e = exp_q.pop_front(); vectors++;
    if (fault !== e.fault) begin
      miscompares++;
      $display("FAIL misalign_sw: fault=%b expected %b", fault, e.fault);
    end
    drive(32'h10, 32'h0, 2'b00, 3'b000, 32'h7F00_4321, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || store_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL misalign_kept: rdata=%h cnt=%h expected %h 0003", rdata, store_cnt, e.rdata);
    end
    drive(32'h21, 32'h55, 2'b10, 3'b000, 32'h0, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || fault !== e.fault) begin
      miscompares++;
      $display("FAIL store_precedence: rdata=%h fault=%b expected rdata=%h fault=%b", rdata, fault, e.rdata, e.fault);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h20, 32'h1111_1111, 2'b11, 3'b000, 32'h0000_5500, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL same_cycle_old: rdata=%h expected %h", rdata, e.rdata);
    end
    drive(32'h20, 32'h2222_2222, 2'b11, 3'b000, 32'h1111_1111, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL same_cycle_b2b: rdata=%h expected %h", rdata, e.rdata);
    end
    drive(32'h20, 32'h0, 2'b00, 3'b000, 32'h2222_2222, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || store_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL same_cycle_new: rdata=%h cnt=%h expected %h 0006", rdata, store_cnt, e.rdata);
    end
  endtask

  task automatic test_async_reset();
    drive(32'h10, 32'h5, 2'b11, 3'b000, 32'h7F00_4321, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL pre_reset: rdata=%h expected %h", rdata, e.rdata);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (rdata !== 32'h0 || store_cnt !== 16'h0 || fault_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: rdata=%h cnt=%h sticky=%b expected 00000000 0000 0", rdata, store_cnt, fault_sticky);
    end
    @(posedge clk); #1;
    vectors++;
    if (rdata !== 32'h0 || store_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_ignores_store: rdata=%h cnt=%h expected 00000000 0000", rdata, store_cnt);
    end
    @(negedge clk);
    dm_op = 2'b00;
    reset = 1'b0;
    drive(32'h40, 32'hCAFE_F00D, 2'b11, 3'b000, 32'h0, 1'b0);
    e = exp_q.pop_front();
    drive(32'h40, 32'h0, 2'b00, 3'b000, 32'hCAFE_F00D, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if (rdata !== e.rdata || store_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL first_edge_after_reset: rdata=%h cnt=%h expected %h 0001", rdata, store_cnt, e.rdata);
    end
  endtask

  task automatic test_saturate();
    drive(32'h44, 32'h1, 2'b11, 3'b000, 32'h0, 1'b0);
    e = exp_q.pop_front();
    repeat (65533) @(posedge clk);
    #1;
    vectors++;
    if (store_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL cnt_fffe: store_cnt=%h expected fffe", store_cnt);
    end
    repeat (7) @(posedge clk);
    #1;
    vectors++;
    if (store_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_saturate: store_cnt=%h expected ffff", store_cnt);
    end
    dm_op = 2'b00;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sw();
    test_sub_word();
    test_fault();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
